// File: rtl/ase_idle_tracker_if.sv
// Request/response monitor bus for the idle tracker: the monitors (master)
// offer traffic and lockdown; the tracker (slave) returns readiness, idle and error status.
interface ase_idle_tracker_if #(
  parameter int NUM_CHANNELS = 2,
  parameter int CNT_WIDTH    = 10
) ();
  localparam int TOT_W = CNT_WIDTH + $clog2(NUM_CHANNELS) + 1;

  logic [NUM_CHANNELS-1:0] req_valid;
  logic [NUM_CHANNELS-1:0] req_ready;
  logic [NUM_CHANNELS-1:0] rsp_valid;
  logic                    reset_lockdown;
  logic                    system_is_idle;
  logic [TOT_W-1:0]        outstanding_total;
  logic                    drain_timeout;
  logic [NUM_CHANNELS-1:0] err_underflow;

  modport master (
    output req_valid, rsp_valid, reset_lockdown,
    input  req_ready, system_is_idle, outstanding_total, drain_timeout, err_underflow
  );

  modport slave (
    input  req_valid, rsp_valid, reset_lockdown,
    output req_ready, system_is_idle, outstanding_total, drain_timeout, err_underflow
  );
endinterface

// File: rtl/ase_idle_tracker.sv
// Per-channel outstanding-transaction tracker producing a debounced system idle level,
// request throttling during reset lockdown, a drain watchdog and underflow error flags.
module ase_idle_tracker #(
  parameter int NUM_CHANNELS  = 2,
  parameter int CNT_WIDTH     = 10,
  parameter int IDLE_HOLD     = 16,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  ase_idle_tracker_if.slave   bus
);
  localparam int TOT_W = CNT_WIDTH + $clog2(NUM_CHANNELS) + 1;
  localparam int QC_W  = $clog2(IDLE_HOLD + 1);
  localparam int DC_W  = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [QC_W-1:0]      QC_ONE  = QC_W'(1);
  localparam logic [QC_W-1:0]      QC_LAST = QC_W'(IDLE_HOLD - 1);
  localparam logic [DC_W-1:0]      DC_MAX  = DC_W'(DRAIN_TIMEOUT);

  localparam logic [1:0] ST_BUSY   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_IDLE   = 2'd2;

  logic [NUM_CHANNELS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_CHANNELS-1:0]                err_q, err_d;
  logic [TOT_W-1:0]                       total_q, total_d;
  logic [1:0]                             state_q, state_d;
  logic [QC_W-1:0]                        qc_q, qc_d;
  logic                                   idle_q, idle_d;
  logic [DC_W-1:0]                        dc_q, dc_d;
  logic                                   dto_q, dto_d;

  logic [NUM_CHANNELS-1:0] ready;
  logic [NUM_CHANNELS-1:0] issue;
  logic                    activity;
  logic                    quiet;

  // A full counter refuses further requests, so the counters can never wrap.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      ready[i] = ~bus.reset_lockdown & (cnt_q[i] != CNT_MAX);
    end
    issue = bus.req_valid & ready;
  end

  always_comb begin
    cnt_d   = cnt_q;
    err_d   = err_q;
    total_d = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      unique case ({issue[i], bus.rsp_valid[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01: begin
          if (cnt_q[i] == '0) err_d[i] = 1'b1;
          else                cnt_d[i] = cnt_q[i] - 1'b1;
        end
        default: cnt_d[i] = cnt_q[i];
      endcase
      total_d = total_d + TOT_W'(cnt_d[i]);
    end
    activity = (|issue) | (|bus.rsp_valid);
    quiet    = (cnt_d == '0) & ~activity;
  end

  // Idle debounce: IDLE_HOLD quiet cycles reach IDLE, one more publishes the level.
  always_comb begin
    state_d = state_q;
    qc_d    = qc_q;
    unique case (state_q)
      ST_BUSY: begin
        if (quiet) begin
          if (IDLE_HOLD == 1) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SETTLE;
            qc_d    = QC_ONE;
          end
        end
      end
      ST_SETTLE: begin
        if (!quiet) begin
          state_d = ST_BUSY;
          qc_d    = '0;
        end else if (qc_q == QC_LAST) begin
          state_d = ST_IDLE;
        end else begin
          qc_d = qc_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (!quiet) begin
          state_d = ST_BUSY;
          qc_d    = '0;
        end
      end
      default: begin
        state_d = ST_BUSY;
        qc_d    = '0;
      end
    endcase
    idle_d = (state_q == ST_IDLE) & quiet;
  end

  // Watchdog pauses (without clearing) while idle; only dropping lockdown clears it.
  always_comb begin
    dc_d = dc_q;
    if (!bus.reset_lockdown) begin
      dc_d = '0;
    end else if (!idle_q && (dc_q != DC_MAX)) begin
      dc_d = dc_q + 1'b1;
    end
    dto_d = bus.reset_lockdown & (dto_q | (dc_d == DC_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      err_q   <= '0;
      total_q <= '0;
      state_q <= ST_BUSY;
      qc_q    <= '0;
      idle_q  <= 1'b0;
      dc_q    <= '0;
      dto_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      total_q <= total_d;
      state_q <= state_d;
      qc_q    <= qc_d;
      idle_q  <= idle_d;
      dc_q    <= dc_d;
      dto_q   <= dto_d;
    end
  end

  assign bus.req_ready         = ready;
  assign bus.system_is_idle    = idle_q;
  assign bus.outstanding_total = total_q;
  assign bus.drain_timeout     = dto_q;
  assign bus.err_underflow     = err_q;

endmodule
